rv_multicycle_ctrl: RTL
=======================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core. It sequences one shared ALU, one unified instruction/data memory port and the register file across fetch, decode, execute, memory and writeback.
- It decodes opcode, funct3 and funct7b5 into mux selects, write strobes and an ALU operation.
- It stalls on a memory-ready handshake and traps on illegal encodings.

Parameters:
- RESET_TRAP_CLEAR, 1, when 1 only reset leaves TRAP; when 0 TRAP returns to FETCH after one cycle.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active
- adr_src  out  1  0 = PC, 1 = result bus
- pc_write  out  1  PC load strobe
- ir_write  out  1  instruction register load strobe
- mem_write  out  1  store strobe
- reg_write  out  1  register file write strobe
- result_src  out  2  00 = alu_out reg, 01 = read data, 10 = alu_result
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  alu_op_t
- instr_retired  out  1  one-cycle pulse per completed instruction
- illegal_instr  out  1  high while in TRAP

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - State goes to FETCH immediately.
  - While rst_n = 0: mem_req, pc_write, ir_write, mem_write, reg_write, instr_retired and illegal_instr are forced to 0. Selects take their FETCH values.
  - Reset in any state, including mid-stall or in TRAP, aborts the instruction. No strobe fires.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, TRAP. Outputs are Moore, except the mem_ready/zero gating noted below.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, ADD (precomputes the branch target).
  - Next state by opcode:
    - LW or SW -> MEMADR
    - R_TYPE -> EXECR
    - I_TYPE -> EXECI
    - J_TYPE -> JAL
    - B_TYPE with funct3=000 -> BEQ
    - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, ADD. Next state is MEMREAD if opcode=LW, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, result_src=00. mem_write=1 for every cycle in this state. Holds until mem_ready=1, then goes to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, funct-decoded op, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, funct-decoded op, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1, then ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=zero, then FETCH.
- Funct decode (used in EXECR and EXECI):
  - funct3=000: SUB when opcode[5]=1 and funct7b5=1, else ADD. SUB therefore applies to R-type only.
  - funct3=010 -> SLT, 110 -> OR, 111 -> AND.
  - Any other funct3 goes to TRAP from DECODE and is never executed.
- imm_src is combinational from opcode: LW or I_TYPE -> 00, SW -> 01, B_TYPE -> 10, J_TYPE -> 11, default 00.
- instr_retired pulses for one cycle in MEMWB, ALUWB, BEQ, and in MEMWRITE on the mem_ready cycle.
- Latencies with zero wait states:
  - LW 5 cycles
  - SW, R-type, I-type and JAL 4 cycles
  - BEQ 3 cycles
  - Each mem_ready=0 cycle adds one cycle.
- TRAP: all strobes 0, illegal_instr=1. Exit per RESET_TRAP_CLEAR.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Decomposition:
- Shared typedef_pkg holds:
  - alu_op_t, 3 bits: ADD=000, SUB=001, AND=010, OR=011, SLT=101
  - inst_t opcodes
  - new state_t enum
  - localparams for the result_src, alu_src_a, alu_src_b and imm_src encodings
- One sub-module, rv_alu_decoder: combinational funct decode from (alu_op class, funct3, opcode[5], funct7b5) to alu_op_t plus an illegal flag. The FSM stays in the top.

Test Plan:
- R-type add (opcode 0110011, funct3 000, funct7b5=0), mem_ready tied 1 -> states FETCH, DECODE, EXECR, ALUWB. alu_control=000 in EXECR. reg_write=1 only in cycle 4. instr_retired pulses once.
- Same instruction with funct7b5=1 -> alu_control=001 (SUB). The same funct3 on I_TYPE with funct7b5=1 -> 000 (ADD).
- LW with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, mem_req=1 throughout, reg_write in MEMWB, total 8 cycles.
- SW with mem_ready=0 for 2 cycles -> mem_write=1 for all 3 MEMWRITE cycles, instr_retired only on the last.
- BEQ with zero=1 then zero=0 -> pc_write=1 and 0 respectively in the BEQ cycle. Each takes 3 cycles.
- Opcode 0000000 -> TRAP, illegal_instr=1, no strobes. Async rst_n pulse asserted mid-cycle -> immediate FETCH, illegal_instr=0, all strobes 0 while reset is low.

Source files
------------

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared types and select encodings for the multicycle RV32I control path.
package rv_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [6:0] {
    OP_LW = 7'b0000011,
    OP_SW = 7'b0100011,
    OP_R  = 7'b0110011,
    OP_I  = 7'b0010011,
    OP_B  = 7'b1100011,
    OP_J  = 7'b1101111
  } inst_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
  } state_t;

  // ALU request class from the FSM: fixed add, fixed sub, or funct-decoded.
  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'b00,
    ALU_CLS_SUB   = 2'b01,
    ALU_CLS_FUNCT = 2'b10
  } alu_cls_t;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_READ    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_B:    return IMM_B;
      OP_J:    return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_alu_decoder.sv
// Funct decode for the shared ALU; illegal reflects funct3 alone so the
// FSM can consult it while still in DECODE.
module rv_alu_decoder
  import rv_multicycle_ctrl_pkg::*;
(
  input  alu_cls_t    cls,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output alu_op_t     alu_op,
  output logic        illegal
);

  alu_op_t funct_op;

  always_comb begin
    funct_op = ALU_ADD;
    illegal  = 1'b0;
    case (funct3)
      3'b000:  funct_op = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_op = ALU_SLT;
      3'b110:  funct_op = ALU_OR;
      3'b111:  funct_op = ALU_AND;
      default: illegal  = 1'b1;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (cls)
      ALU_CLS_SUB:   alu_op = ALU_SUB;
      ALU_CLS_FUNCT: alu_op = funct_op;
      default:       alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over one ALU and one memory port.
module rv_multicycle_ctrl
  import rv_multicycle_ctrl_pkg::*;
#(
  parameter bit RESET_TRAP_CLEAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_retired,
  output logic       illegal_instr,
  output state_t     state
);

  // Memory handshake: mem_req holds the access open; the access completes
  // on the cycle where mem_req && mem_ready, and only then does the FSM
  // advance. mem_ready is ignored in every state that does not request.

  state_t   next_state;
  alu_cls_t alu_cls;
  alu_op_t  alu_op;
  logic     funct_illegal;

  rv_alu_decoder u_alu_decoder (
    .cls      (alu_cls),
    .funct3   (funct3),
    .op5      (opcode[5]),
    .funct7b5 (funct7b5),
    .alu_op   (alu_op),
    .illegal  (funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    result_src    = RES_ALU_OUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_cls       = ALU_CLS_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = funct_illegal ? S_TRAP : S_EXECR;
          OP_I:         next_state = funct_illegal ? S_TRAP : S_EXECI;
          OP_J:         next_state = S_JAL;
          OP_B:         next_state = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_READ;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req       = 1'b1;
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_cls    = ALU_CLS_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_cls    = ALU_CLS_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a     = SRCA_RS1;
        alu_cls       = ALU_CLS_SUB;
        pc_write      = zero;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
        if (!RESET_TRAP_CLEAR) next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // State is already FETCH during reset; only the strobes need masking.
    if (!rst_n) begin
      mem_req       = 1'b0;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  assign alu_control = alu_op;
  assign imm_src     = imm_sel(opcode);

endmodule
